// File: rtl/pipe_ctrl_seq.sv
// Pipeline sequencer for the 5-stage RV32 core: stage write enables, flush/bubble
// control, load-use stall counting and saturating stall/flush performance counters.
module pipe_ctrl_seq #(
  parameter int STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             halt,
  input  logic             perf_clear,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic [1:0]       stall_counter,
  output logic             halted,
  output logic [CNT_W-1:0] perf_stall_cycles,
  output logic [CNT_W-1:0] perf_flushes
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [1:0] STALL_LAST = 2'(STALL_CYCLES - 1);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_evt;
  logic             flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Next-state and Mealy output decode; the redirect case is shared by RUN, LSTALL and FLUSH.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_we     = 1'b0;
    stall_counter = 2'd0;
    halted        = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;

    if (reset) begin
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end else if (mem_busy && (state_q != ST_HALTED)) begin
      stall_evt = 1'b1;
      if (state_q == ST_LSTALL) begin
        stall_counter = cnt_q;
      end else begin
        stall_counter = 2'd0;
      end
    end else if ((state_q != ST_HALTED) && branch_taken) begin
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_we     = 1'b1;
      id_ex_bubble = 1'b1;
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      flush_evt    = 1'b1;
      state_d      = ST_FLUSH;
      cnt_d        = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt) begin
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            mem_wb_we    = 1'b1;
            state_d      = ST_HALTED;
          end else if (hazard) begin
            id_ex_we     = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_we    = 1'b1;
            mem_wb_we    = 1'b1;
            stall_evt    = 1'b1;
            if (STALL_CYCLES > 1) begin
              state_d = ST_LSTALL;
              cnt_d   = 2'd1;
            end else begin
              state_d = ST_RUN;
              cnt_d   = 2'd0;
            end
          end else begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
          end
        end
        ST_LSTALL: begin
          id_ex_we      = 1'b1;
          id_ex_bubble  = 1'b1;
          ex_mem_we     = 1'b1;
          mem_wb_we     = 1'b1;
          stall_counter = cnt_q;
          stall_evt     = 1'b1;
          if (cnt_q == STALL_LAST) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        ST_FLUSH: begin
          // Wrong-path hazard/halt are dropped; only the counter decides the exit.
          pc_we        = 1'b1;
          if_id_we     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
          if (cnt_q == FLUSH_LAST) begin
            state_d = ST_RUN;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        ST_HALTED: begin
          halted       = 1'b1;
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Performance counter next values; clear wins over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (reset || perf_clear) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (stall_evt) begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (flush_evt) begin
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // Sequencer state and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flushes      = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Directed bench for pipe_ctrl_seq: a default instance plus a CNT_W=4 instance
// sharing the same stimulus for the saturation checks.
module tb_pipe_ctrl_seq;

  logic clk = 1'b0;
  logic reset, hazard, branch_taken, mem_busy, halt, perf_clear;

  logic        pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we;
  logic [1:0]  stall_counter;
  logic        halted;
  logic [15:0] perf_stall_cycles, perf_flushes;

  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_we, s_id_ex_bubble, s_ex_mem_we, s_mem_wb_we;
  logic [1:0]  s_stall_counter;
  logic        s_halted;
  logic [3:0]  s_perf_stall_cycles, s_perf_flushes;

  int checks = 0;
  int errors = 0;

  // Bit order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we
  localparam logic [6:0] V_RESET  = 7'b0000000;
  localparam logic [6:0] V_RUN    = 7'b1101011;
  localparam logic [6:0] V_REDIR  = 7'b1111111;
  localparam logic [6:0] V_HOLD   = 7'b0001111;
  localparam logic [6:0] V_FREEZE = 7'b0000000;

  logic [6:0] vec;
  assign vec = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_we};

  always #5 clk = ~clk;

  pipe_ctrl_seq #(.STALL_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .hazard(hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt(halt), .perf_clear(perf_clear),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .stall_counter(stall_counter), .halted(halted),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
  );

  pipe_ctrl_seq #(.STALL_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .hazard(hazard), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt(halt), .perf_clear(perf_clear),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_ex_we(s_id_ex_we), .id_ex_bubble(s_id_ex_bubble), .ex_mem_we(s_ex_mem_we),
    .mem_wb_we(s_mem_wb_we), .stall_counter(s_stall_counter), .halted(s_halted),
    .perf_stall_cycles(s_perf_stall_cycles), .perf_flushes(s_perf_flushes)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hazard = 1'b0; branch_taken = 1'b0;
    mem_busy = 1'b0; halt = 1'b0; perf_clear = 1'b0;
    tick(); tick();
    #1;
    chk("reset_vec", {25'd0, vec}, {25'd0, V_RESET});
    chk("reset_sc", {30'd0, stall_counter}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_perf_stall", {16'd0, perf_stall_cycles}, 32'd0);
    chk("reset_perf_flush", {16'd0, perf_flushes}, 32'd0);

    // Idle run for five cycles
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #1;
    chk("idle_vec", {25'd0, vec}, {25'd0, V_RUN});
    chk("idle_sc", {30'd0, stall_counter}, 32'd0);
    chk("idle_perf_stall", {16'd0, perf_stall_cycles}, 32'd0);
    chk("idle_perf_flush", {16'd0, perf_flushes}, 32'd0);

    // Single-cycle load-use hazard
    hazard = 1'b1; #1;
    chk("lu_c0_vec", {25'd0, vec}, {25'd0, V_HOLD});
    chk("lu_c0_sc", {30'd0, stall_counter}, 32'd0);
    tick(); hazard = 1'b0; #1;
    chk("lu_c1_vec", {25'd0, vec}, {25'd0, V_HOLD});
    chk("lu_c1_sc", {30'd0, stall_counter}, 32'd1);
    tick(); #1;
    chk("lu_c2_vec", {25'd0, vec}, {25'd0, V_RUN});
    chk("lu_perf_stall", {16'd0, perf_stall_cycles}, 32'd2);

    // Branch and hazard together: the branch wins
    perf_clear = 1'b1; tick(); perf_clear = 1'b0; #1;
    chk("clr_perf_stall", {16'd0, perf_stall_cycles}, 32'd0);
    branch_taken = 1'b1; hazard = 1'b1; #1;
    chk("br_c0_vec", {25'd0, vec}, {25'd0, V_REDIR});
    tick(); branch_taken = 1'b0; hazard = 1'b0; #1;
    chk("br_c1_vec", {25'd0, vec}, {25'd0, V_REDIR});
    tick(); #1;
    chk("br_c2_vec", {25'd0, vec}, {25'd0, V_RUN});
    chk("br_perf_flush", {16'd0, perf_flushes}, 32'd1);
    chk("br_perf_stall", {16'd0, perf_stall_cycles}, 32'd0);

    // Branch arriving mid-stall abandons the stall
    hazard = 1'b1; tick(); hazard = 1'b0; branch_taken = 1'b1; #1;
    chk("lsbr_vec", {25'd0, vec}, {25'd0, V_REDIR});
    chk("lsbr_sc", {30'd0, stall_counter}, 32'd0);
    tick(); branch_taken = 1'b0; #1;
    chk("lsbr_flush_vec", {25'd0, vec}, {25'd0, V_REDIR});
    tick(); #1;
    chk("lsbr_run_vec", {25'd0, vec}, {25'd0, V_RUN});
    chk("lsbr_perf_flush", {16'd0, perf_flushes}, 32'd2);
    chk("lsbr_perf_stall", {16'd0, perf_stall_cycles}, 32'd1);

    // Memory freeze in the middle of a load-use stall
    perf_clear = 1'b1; tick(); perf_clear = 1'b0;
    hazard = 1'b1; #1;
    chk("fz_c0_vec", {25'd0, vec}, {25'd0, V_HOLD});
    tick(); hazard = 1'b0; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fz_busy_vec", {25'd0, vec}, {25'd0, V_FREEZE});
      chk("fz_busy_sc", {30'd0, stall_counter}, 32'd1);
      tick();
    end
    mem_busy = 1'b0; #1;
    chk("fz_rel_vec", {25'd0, vec}, {25'd0, V_HOLD});
    chk("fz_rel_sc", {30'd0, stall_counter}, 32'd1);
    tick(); #1;
    chk("fz_run_vec", {25'd0, vec}, {25'd0, V_RUN});
    chk("fz_perf_stall", {16'd0, perf_stall_cycles}, 32'd5);

    // Halt is sticky and ignores mem_busy/hazard until reset
    halt = 1'b1; #1;
    chk("ht_c0_vec", {25'd0, vec}, {25'd0, V_HOLD});
    chk("ht_c0_halted", {31'd0, halted}, 32'd0);
    tick(); halt = 1'b0; mem_busy = 1'b1; hazard = 1'b1; #1;
    chk("ht_c1_halted", {31'd0, halted}, 32'd1);
    chk("ht_c1_vec", {25'd0, vec}, {25'd0, V_HOLD});
    tick(); #1;
    chk("ht_c2_halted", {31'd0, halted}, 32'd1);
    chk("ht_c2_vec", {25'd0, vec}, {25'd0, V_HOLD});
    chk("ht_perf_stall", {16'd0, perf_stall_cycles}, 32'd5);
    mem_busy = 1'b0; hazard = 1'b0; reset = 1'b1; #1;
    chk("ht_rst_vec", {25'd0, vec}, {25'd0, V_RESET});
    tick(); reset = 1'b0; #1;
    chk("ht_after_halted", {31'd0, halted}, 32'd0);
    chk("ht_after_vec", {25'd0, vec}, {25'd0, V_RUN});

    // Saturation on the 4-bit instance, then clear racing a stall cycle
    hazard = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    #1;
    chk("sat_perf_stall4", {28'd0, s_perf_stall_cycles}, 32'd15);
    chk("sat_perf_stall16", {16'd0, perf_stall_cycles}, 32'd20);
    tick(); #1;
    chk("sat_hold_stall4", {28'd0, s_perf_stall_cycles}, 32'd15);
    perf_clear = 1'b1; tick(); perf_clear = 1'b0; hazard = 1'b0; #1;
    chk("sat_clr_stall4", {28'd0, s_perf_stall_cycles}, 32'd0);
    chk("sat_clr_stall16", {16'd0, perf_stall_cycles}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
